// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcodes, ALUop codes, control word and opcode check for the multicycle MIPS controller
package mips_ctrl_pkg;
  localparam int STATE_W = 4;
  localparam int OP_W = 6;
  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;
  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational state -> control word (in: state_i; out: ctrl_o incl. pc_write/pc_write_cond)
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_rd    = 1'b1;
        ctrl_o.ir_wr     = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_write  = 1'b1;
      end
      DECODE: begin
        ctrl_o.alu_src_b = 2'b11;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl_o.mem_rd = 1'b1;
        ctrl_o.iord   = 1'b1;
      end
      MEMWR: begin
        ctrl_o.mem_wr     = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMWB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ADDIWB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_src        = 2'b01;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl_o.pc_src     = 2'b10;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS Moore control FSM (in: clk, rst, opcode, zero; out: datapath enables/selects, ALUop, instrDone, sticky illegal, debug state)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int SW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           pcEn,
  output logic           IorD,
  output logic           memRd,
  output logic           memWr,
  output logic           irWr,
  output logic           memToReg,
  output logic           regDst,
  output logic           regWr,
  output logic           ALUsrcA,
  output logic [1:0]     ALUsrcB,
  output logic [1:0]     ALUop,
  output logic [1:0]     PCsrc,
  output logic           instrDone,
  output logic           illegal,
  output logic [SW-1:0]  state
);
  state_t state_q, state_d;
  logic   illegal_q;
  logic   op_ok;
  ctrl_t  ctrl;
  assign op_ok = op_valid(OP_W'(opcode));
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                        opcode == OP_RTYPE ? EXEC :
                        opcode == OP_BEQ   ? BRANCH :
                        opcode == OP_J     ? JUMP :
                        opcode == OP_ADDI  ? ADDIEX : FETCH;
      MEMADR: state_d = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE && !op_ok) illegal_q <= 1'b1;
    end
  end
  // during reset the datapath sees FETCH selects with every write enable held off
  mips_ctrl_decode u_decode (
    .state_i(rst ? FETCH : state_q),
    .ctrl_o (ctrl)
  );
  assign pcEn      = !rst && (ctrl.pc_write || (ctrl.pc_write_cond && zero));
  assign irWr      = !rst && ctrl.ir_wr;
  assign regWr     = !rst && ctrl.reg_wr;
  assign memWr     = !rst && ctrl.mem_wr;
  // an unsupported opcode ends its instruction in DECODE
  assign instrDone = !rst && (ctrl.instr_done || (state_q == DECODE && !op_ok));
  assign IorD      = ctrl.iord;
  assign memRd     = ctrl.mem_rd;
  assign memToReg  = ctrl.mem_to_reg;
  assign regDst    = ctrl.reg_dst;
  assign ALUsrcA   = ctrl.alu_src_a;
  assign ALUsrcB   = ctrl.alu_src_b;
  assign ALUop     = ctrl.alu_op;
  assign PCsrc     = ctrl.pc_src;
  assign illegal   = illegal_q;
  assign state     = SW'(state_q);
endmodule
